cache_line_mover: RTL and testbench

CACHE_LINE_MOVER -- requirements
Module: cache_line_mover

---
 rtl/cache_line_mover.sv | 134 +++++++++++++
 tb/tb_cache_line_mover.sv | 316 +++++++++++++++++++++++++++++++
 2 files changed

// File: rtl/cache_line_mover.sv
// Moves one 128-bit cache line between the data array and a 16-bit memory port:
// optional writeback (array -> memory), then optional fill (memory -> array), through one line buffer.
module cache_line_mover (
  input  logic         main_clk,
  input  logic         main_rst_n,
  input  logic         req_valid,
  output logic         req_ready,
  input  logic         req_writeback,
  input  logic         req_fill,
  input  logic [8:0]   req_segment,
  input  logic [1:0]   req_way,
  input  logic [21:0]  req_wb_addr,
  input  logic [21:0]  req_fill_addr,
  output logic [8:0]   cache_segment,
  output logic [1:0]   cache_way,
  output logic         cache_full_write,
  output logic [127:0] cache_write_data,
  input  logic [127:0] cache_read_data,
  output logic         mem_cmd_valid,
  input  logic         mem_cmd_ready,
  output logic         mem_cmd_write,
  output logic [21:0]  mem_cmd_addr,
  output logic         mem_wdata_valid,
  input  logic         mem_wdata_ready,
  output logic [15:0]  mem_wdata,
  input  logic         mem_rdata_valid,
  input  logic [15:0]  mem_rdata,
  output logic         busy,
  output logic         done
);

  typedef enum logic [3:0] {
    IDLE, WB_READ, WB_CAPTURE, WB_CMD, WB_DATA,
    FILL_CMD, FILL_DATA, FILL_WRITE, DONE
  } state_t;

  typedef struct packed {
    logic        wb;
    logic        fill;
    logic [8:0]  seg;
    logic [1:0]  way;
    logic [21:0] wb_addr;
    logic [21:0] fill_addr;
  } req_t;

  state_t       state_q, state_d;
  req_t         req_q;
  logic [2:0]   beat_q;
  logic [127:0] line_q;

  always_ff @(posedge main_clk or negedge main_rst_n) begin
    if (!main_rst_n) state_q <= IDLE;
    else             state_q <= state_d;
  end

  always_comb begin
    state_d          = state_q;
    req_ready        = 1'b0;
    busy             = 1'b1;
    done             = 1'b0;
    mem_cmd_valid    = 1'b0;
    mem_cmd_write    = 1'b0;
    mem_cmd_addr     = req_q.fill_addr;
    mem_wdata_valid  = 1'b0;
    cache_full_write = 1'b0;
    case (state_q)
      IDLE: begin
        req_ready = 1'b1;
        busy      = 1'b0;
        if (req_valid)
          state_d = req_writeback ? WB_READ : (req_fill ? FILL_CMD : DONE);
      end
      // Array output is registered: address in WB_READ, data sampled in WB_CAPTURE.
      WB_READ:    state_d = WB_CAPTURE;
      WB_CAPTURE: state_d = WB_CMD;
      WB_CMD: begin
        mem_cmd_valid = 1'b1;
        mem_cmd_write = 1'b1;
        mem_cmd_addr  = req_q.wb_addr;
        if (mem_cmd_ready) state_d = WB_DATA;
      end
      WB_DATA: begin
        mem_wdata_valid = 1'b1;
        if (mem_wdata_ready && beat_q == 3'd7)
          state_d = req_q.fill ? FILL_CMD : DONE;
      end
      FILL_CMD: begin
        mem_cmd_valid = 1'b1;
        if (mem_cmd_ready) state_d = FILL_DATA;
      end
      FILL_DATA: if (mem_rdata_valid && beat_q == 3'd7) state_d = FILL_WRITE;
      FILL_WRITE: begin
        cache_full_write = 1'b1;
        state_d          = DONE;
      end
      DONE: begin
        done    = 1'b1;
        state_d = IDLE;
      end
      default: state_d = IDLE;
    endcase
  end

  // Beat counter is shared by both directions; it wraps to 0 after beat 7.
  always_ff @(posedge main_clk or negedge main_rst_n) begin
    if (!main_rst_n) begin
      req_q  <= '0;
      beat_q <= '0;
      line_q <= '0;
    end else begin
      if (req_valid && req_ready)
        req_q <= '{wb: req_writeback, fill: req_fill, seg: req_segment, way: req_way,
                   wb_addr: req_wb_addr, fill_addr: req_fill_addr};
      case (state_q)
        WB_CAPTURE: line_q <= cache_read_data;
        WB_DATA:    if (mem_wdata_ready) beat_q <= beat_q + 3'd1;
        FILL_CMD:   if (mem_cmd_ready) beat_q <= '0;
        FILL_DATA: begin
          if (mem_rdata_valid) begin
            line_q[{beat_q, 4'b0000} +: 16] <= mem_rdata;
            beat_q                          <= beat_q + 3'd1;
          end
        end
        default: ;
      endcase
    end
  end

  assign cache_segment    = req_q.seg;
  assign cache_way        = req_q.way;
  assign cache_write_data = line_q;
  assign mem_wdata        = line_q[{beat_q, 4'b0000} +: 16];

endmodule

// File: tb/tb_cache_line_mover.sv
// Directed bench for cache_line_mover: a vector table of line moves run against a
// small memory/array responder, plus hand sequences for reset, stray data and no-op requests.
module tb_cache_line_mover;

  logic         main_clk = 1'b0;
  logic         main_rst_n = 1'b0;
  logic         req_valid = 1'b0, req_ready;
  logic         req_writeback = 1'b0, req_fill = 1'b0;
  logic [8:0]   req_segment = '0;
  logic [1:0]   req_way = '0;
  logic [21:0]  req_wb_addr = '0, req_fill_addr = '0;
  logic [8:0]   cache_segment;
  logic [1:0]   cache_way;
  logic         cache_full_write;
  logic [127:0] cache_write_data;
  logic [127:0] cache_read_data = '0;
  logic         mem_cmd_valid, mem_cmd_ready = 1'b0, mem_cmd_write;
  logic [21:0]  mem_cmd_addr;
  logic         mem_wdata_valid, mem_wdata_ready = 1'b0;
  logic [15:0]  mem_wdata;
  logic         mem_rdata_valid = 1'b0;
  logic [15:0]  mem_rdata = '0;
  logic         busy, done;

  cache_line_mover dut (
    .main_clk(main_clk), .main_rst_n(main_rst_n),
    .req_valid(req_valid), .req_ready(req_ready),
    .req_writeback(req_writeback), .req_fill(req_fill),
    .req_segment(req_segment), .req_way(req_way),
    .req_wb_addr(req_wb_addr), .req_fill_addr(req_fill_addr),
    .cache_segment(cache_segment), .cache_way(cache_way),
    .cache_full_write(cache_full_write), .cache_write_data(cache_write_data),
    .cache_read_data(cache_read_data),
    .mem_cmd_valid(mem_cmd_valid), .mem_cmd_ready(mem_cmd_ready),
    .mem_cmd_write(mem_cmd_write), .mem_cmd_addr(mem_cmd_addr),
    .mem_wdata_valid(mem_wdata_valid), .mem_wdata_ready(mem_wdata_ready),
    .mem_wdata(mem_wdata),
    .mem_rdata_valid(mem_rdata_valid), .mem_rdata(mem_rdata),
    .busy(busy), .done(done)
  );

  always #5 main_clk = ~main_clk;

  typedef struct {
    logic         wb;
    logic         fill;
    logic [8:0]   seg;
    logic [1:0]   way;
    logic [21:0]  wb_addr;
    logic [21:0]  fill_addr;
    logic [127:0] rd_line;    // array contents at seg/way
    logic [127:0] fill_line;  // memory contents returned on read
    logic         wr_toggle;  // mem_wdata_ready toggles instead of staying high
    logic         rd_gap;     // idle cycles between read beats
    logic         stray;      // junk mem_rdata_valid whenever no read is outstanding
    int           exp_beats;
    int           exp_cfw;
    logic [127:0] exp_line;
  } vec_t;

  localparam logic [127:0] JUNK = {8{16'h5A5A}};

  vec_t cur;
  int   n_chk = 0, n_fail = 0;

  // Observation state, written only by the monitor.
  int          cyc = 0;
  logic        cmd_w[$];
  logic [21:0] cmd_a[$];
  logic [15:0] wbeats[$];
  int          cfw_cnt = 0, done_cnt = 0, hold_err = 0;
  int          cfw_cyc = 0, done_cyc = 0, rd_cyc = 0, wb_last_cyc = 0;
  logic [127:0] cfw_line = '0;
  logic [8:0]  done_seg = '0;
  logic [1:0]  done_way = '0;
  logic        cmd_wait = 1'b0, wd_wait = 1'b0, hold_w = 1'b0;
  logic [21:0] hold_a = '0;
  logic [15:0] hold_d = '0;

  // Registered data array: correct line only when addressed at the current target.
  always @(posedge main_clk)
    cache_read_data <= (cache_segment == cur.seg && cache_way == cur.way) ? cur.rd_line
                                                                         : cur.rd_line ^ JUNK;

  always @(posedge main_clk) begin
    cyc <= cyc + 1;
    if (!main_rst_n) begin
      cmd_wait <= 1'b0;
      wd_wait  <= 1'b0;
    end else begin
      if (mem_cmd_valid && mem_cmd_ready) begin
        cmd_w.push_back(mem_cmd_write);
        cmd_a.push_back(mem_cmd_addr);
        if (!mem_cmd_write) rd_cyc <= cyc;
      end
      if (cmd_wait && (!mem_cmd_valid || mem_cmd_addr != hold_a || mem_cmd_write != hold_w))
        hold_err <= hold_err + 1;
      cmd_wait <= mem_cmd_valid && !mem_cmd_ready;
      hold_a   <= mem_cmd_addr;
      hold_w   <= mem_cmd_write;
      if (mem_wdata_valid && mem_wdata_ready) begin
        wbeats.push_back(mem_wdata);
        wb_last_cyc <= cyc;
      end
      if (wd_wait && (!mem_wdata_valid || mem_wdata != hold_d))
        hold_err <= hold_err + 1;
      wd_wait <= mem_wdata_valid && !mem_wdata_ready;
      hold_d  <= mem_wdata;
      if (cache_full_write) begin
        cfw_cnt  <= cfw_cnt + 1;
        cfw_line <= cache_write_data;
        cfw_cyc  <= cyc;
      end
      if (done) begin
        done_cnt <= done_cnt + 1;
        done_cyc <= cyc;
        done_seg <= cache_segment;
        done_way <= cache_way;
      end
    end
  end

  task automatic chk(input string name, input logic [127:0] act, input logic [127:0] exp);
    n_chk++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %h expected %h", name, act, exp);
    end
  endtask

  int   rd_beat, cmd_base, wb_base, cfw_base, done_base, herr_base;
  logic gap_ph;

  task automatic snapshot();
    rd_beat   = 0;
    gap_ph    = 1'b0;
    cmd_base  = cmd_w.size();
    wb_base   = wbeats.size();
    cfw_base  = cfw_cnt;
    done_base = done_cnt;
    herr_base = hold_err;
  endtask

  // One negedge worth of memory-side stimulus.
  task automatic drive_mem();
    logic rd_pend;
    rd_pend         = (cmd_w.size() > cmd_base) && (cmd_w[cmd_w.size()-1] == 1'b0);
    mem_cmd_ready   = ~mem_cmd_ready;
    mem_wdata_ready = cur.wr_toggle ? ~mem_wdata_ready : 1'b1;
    gap_ph          = ~gap_ph;
    if (rd_pend && rd_beat < 8 && !(cur.rd_gap && gap_ph)) begin
      mem_rdata_valid = 1'b1;
      mem_rdata       = cur.fill_line[rd_beat*16 +: 16];
      rd_beat++;
    end else begin
      mem_rdata_valid = cur.stray && !rd_pend;
      mem_rdata       = 16'hDEAD;
    end
  endtask

  task automatic mem_idle();
    mem_rdata_valid = 1'b0;
    mem_cmd_ready   = 1'b0;
    mem_wdata_ready = 1'b0;
  endtask

  task automatic issue(input vec_t v);
    @(negedge main_clk);
    req_valid     = 1'b1;
    req_writeback = v.wb;
    req_fill      = v.fill;
    req_segment   = v.seg;
    req_way       = v.way;
    req_wb_addr   = v.wb_addr;
    req_fill_addr = v.fill_addr;
    @(negedge main_clk);
    req_valid = 1'b0;
  endtask

  task automatic run_op(input vec_t v, input string tag);
    int n;
    cur = v;
    snapshot();
    issue(v);
    n = 0;
    while (done_cnt == done_base && n < 300) begin
      drive_mem();
      @(negedge main_clk);
      n++;
    end
    mem_idle();
    chk({tag, ".no_timeout"}, n < 300, 1'b1);
    chk({tag, ".ncmd"}, cmd_w.size() - cmd_base, v.wb + v.fill);
    if (v.wb && cmd_w.size() > cmd_base) begin
      chk({tag, ".wb_cmd_write"}, cmd_w[cmd_base], 1'b1);
      chk({tag, ".wb_cmd_addr"}, cmd_a[cmd_base], v.wb_addr);
    end
    if (v.fill && cmd_w.size() > cmd_base) begin
      chk({tag, ".rd_cmd_write"}, cmd_w[cmd_w.size()-1], 1'b0);
      chk({tag, ".rd_cmd_addr"}, cmd_a[cmd_w.size()-1], v.fill_addr);
    end
    chk({tag, ".nbeats"}, wbeats.size() - wb_base, v.exp_beats);
    for (int k = 0; k < v.exp_beats && wb_base + k < wbeats.size(); k++)
      chk($sformatf("%s.beat%0d", tag, k), wbeats[wb_base+k], v.rd_line[k*16 +: 16]);
    chk({tag, ".ncfw"}, cfw_cnt - cfw_base, v.exp_cfw);
    if (v.exp_cfw > 0) begin
      chk({tag, ".cfw_line"}, cfw_line, v.exp_line);
      chk({tag, ".done_after_cfw"}, done_cyc - cfw_cyc, 1);
    end
    if (v.wb && v.fill) chk({tag, ".wb_before_rd"}, wb_last_cyc < rd_cyc, 1'b1);
    chk({tag, ".ndone"}, done_cnt - done_base, 1);
    chk({tag, ".seg_at_done"}, done_seg, v.seg);
    chk({tag, ".way_at_done"}, done_way, v.way);
    chk({tag, ".hold"}, hold_err - herr_base, 0);
    chk({tag, ".idle_after"}, {req_ready, busy, done}, 3'b100);
  endtask

  vec_t tbl[5];
  vec_t rv;

  initial begin
    tbl[0] = '{wb:0, fill:1, seg:9'h0A5, way:2'd1, wb_addr:22'h0, fill_addr:22'h00123,
               rd_line:128'h0, fill_line:128'h8888_7777_6666_5555_4444_3333_2222_1111,
               wr_toggle:0, rd_gap:0, stray:0, exp_beats:0, exp_cfw:1,
               exp_line:128'h8888_7777_6666_5555_4444_3333_2222_1111};
    tbl[1] = '{wb:1, fill:0, seg:9'h011, way:2'd2, wb_addr:22'h3ABCD, fill_addr:22'h0,
               rd_line:128'h000F_000E_000D_000C_000B_000A_0009_0008, fill_line:128'h0,
               wr_toggle:0, rd_gap:0, stray:1, exp_beats:8, exp_cfw:0, exp_line:128'h0};
    tbl[2] = '{wb:1, fill:0, seg:9'h100, way:2'd0, wb_addr:22'h00001, fill_addr:22'h0,
               rd_line:128'h1234_5678_9ABC_DEF0_0F1E_2D3C_4B5A_6978, fill_line:128'h0,
               wr_toggle:1, rd_gap:0, stray:0, exp_beats:8, exp_cfw:0, exp_line:128'h0};
    tbl[3] = '{wb:1, fill:1, seg:9'h0C3, way:2'd3, wb_addr:22'h155555, fill_addr:22'h2AAAAA,
               rd_line:128'hAAAA_BBBB_CCCC_DDDD_EEEE_FFFF_1357_2468,
               fill_line:128'hCAFE_BABE_DEAD_BEEF_0123_4567_89AB_CDEF,
               wr_toggle:1, rd_gap:0, stray:1, exp_beats:8, exp_cfw:1,
               exp_line:128'hCAFE_BABE_DEAD_BEEF_0123_4567_89AB_CDEF};
    tbl[4] = '{wb:0, fill:1, seg:9'h1FF, way:2'd3, wb_addr:22'h0, fill_addr:22'h3FFFFF,
               rd_line:128'h0, fill_line:128'hFFFF_0000_F0F0_0F0F_A5A5_5A5A_0001_8000,
               wr_toggle:0, rd_gap:1, stray:1, exp_beats:0, exp_cfw:1,
               exp_line:128'hFFFF_0000_F0F0_0F0F_A5A5_5A5A_0001_8000};
    cur = tbl[0];

    // Reset state, asynchronous: visible before any clock edge.
    #1;
    chk("rst.req_ready", req_ready, 1'b1);
    chk("rst.busy_done", {busy, done}, 2'b00);
    chk("rst.valids", {mem_cmd_valid, mem_wdata_valid, cache_full_write}, 3'b000);
    chk("rst.line", cache_write_data, 128'h0);
    repeat (2) @(negedge main_clk);
    main_rst_n = 1'b1;

    run_op(tbl[0], "v0_fill");

    // Stray read data while idle must not touch the line buffer.
    for (int i = 0; i < 3; i++) begin
      @(negedge main_clk);
      mem_rdata_valid = 1'b1;
      mem_rdata       = 16'hBAD0 + 16'(i);
    end
    @(negedge main_clk);
    mem_rdata_valid = 1'b0;
    chk("stray_idle.line", cache_write_data, tbl[0].exp_line);
    chk("stray_idle.state", {req_ready, busy}, 2'b10);

    for (int i = 1; i < 5; i++) run_op(tbl[i], $sformatf("v%0d", i));

    // Neither operation: accepted straight into DONE.
    rv = '{wb:0, fill:0, seg:9'h077, way:2'd1, wb_addr:22'h0, fill_addr:22'h0,
           rd_line:128'h0, fill_line:128'h0, wr_toggle:0, rd_gap:0, stray:0,
           exp_beats:0, exp_cfw:0, exp_line:128'h0};
    cur = rv;
    snapshot();
    @(negedge main_clk);
    req_valid = 1'b1; req_writeback = 1'b0; req_fill = 1'b0; req_segment = rv.seg; req_way = rv.way;
    chk("noop.accept_cycle", {req_ready, done}, 2'b10);
    @(negedge main_clk);
    req_valid = 1'b0;
    chk("noop.done_pulse", {req_ready, busy, done}, 3'b011);
    @(negedge main_clk);
    chk("noop.back_idle", {req_ready, busy, done}, 3'b100);
    chk("noop.no_cmd", cmd_w.size() - cmd_base, 0);

    // Reset in the middle of a fill, after four read beats.
    rv = '{wb:0, fill:1, seg:9'h033, way:2'd2, wb_addr:22'h0, fill_addr:22'h0BEEF,
           rd_line:128'h0, fill_line:128'h1010_2020_3030_4040_5050_6060_7070_8080,
           wr_toggle:0, rd_gap:0, stray:0, exp_beats:0, exp_cfw:1,
           exp_line:128'h1010_2020_3030_4040_5050_6060_7070_8080};
    cur = rv;
    snapshot();
    issue(rv);
    for (int n = 0; n < 100 && rd_beat < 4; n++) begin
      drive_mem();
      @(negedge main_clk);
    end
    chk("rstmid.reached_beat4", rd_beat, 4);
    mem_idle();
    main_rst_n = 1'b0;
    #1;
    chk("rstmid.idle", {req_ready, busy, done}, 3'b100);
    chk("rstmid.valids", {mem_cmd_valid, mem_wdata_valid, cache_full_write}, 3'b000);
    chk("rstmid.line_clr", cache_write_data, 128'h0);
    chk("rstmid.seg_clr", {cache_segment, cache_way}, 11'h0);
    repeat (2) @(negedge main_clk);
    main_rst_n = 1'b1;
    repeat (3) @(negedge main_clk);
    chk("rstmid.no_cfw", cfw_cnt - cfw_base, 0);
    chk("rstmid.no_done", done_cnt - done_base, 0);
    rv.fill_line = 128'h0BAD_F00D_1234_4321_ABCD_DCBA_5555_AAAA;
    rv.exp_line  = rv.fill_line;
    run_op(rv, "after_rst");

    $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
    $finish;
  end

endmodule
